// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory programming controller:
// controller states, the default no-op word and address-width helpers.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PROG = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   // RV32I "addi x0, x0, 0"
   localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic bit is_pow2(input int depth);
      return (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/imem_prog_ctrl_edge_detect.sv
// Rising-edge detector producing a one-cycle pulse; an input already high
// across reset release is not treated as a new edge.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic din_p1;
   logic blk_p1;

   // Stage p1: previous input value, plus a one-cycle mask after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         din_p1 <= 1'b0;
         blk_p1 <= din;
      end else begin
         din_p1 <= din;
         blk_p1 <= 1'b0;
      end
   end

   assign pulse = din & ~din_p1 & ~blk_p1;

endmodule

// File: rtl/imem_prog_ctrl.sv
// Instruction-memory programming controller: button-style pointer control
// and word writes while idle/programming, zero-latency CPU fetch in RUN.
module imem_prog_ctrl
   import imem_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 64,
   parameter bit               AUTO_INC = 1'b0,
   parameter logic [XLEN-1:0]  NOP_WORD = XLEN'(IMEM_NOP_WORD),
   localparam int              AW       = addr_w(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] Imem_write_instr,
   input  logic            Imem_write_en,
   input  logic            Up,
   input  logic            Down,
   input  logic            Set,
   input  logic [AW-1:0]   set_addr,
   input  logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] fetch_instr,
   output logic [AW-1:0]   prog_ptr,
   output logic            running,
   output logic            prog_err
);

   logic up_e, dn_e, set_e, wr_e;

   edge_detect u_up  (.clk(clk), .reset(reset), .din(Up),            .pulse(up_e));
   edge_detect u_dn  (.clk(clk), .reset(reset), .din(Down),          .pulse(dn_e));
   edge_detect u_set (.clk(clk), .reset(reset), .din(Set),           .pulse(set_e));
   edge_detect u_wr  (.clk(clk), .reset(reset), .din(Imem_write_en), .pulse(wr_e));

   state_e          state;
   logic [XLEN-1:0] mem [DEPTH];
   logic            any_e;
   logic            wr_ok;
   logic [AW-1:0]   ptr_nxt;
   logic [AW-1:0]   fetch_idx;
   logic            pc_ok;

   assign any_e = up_e | dn_e | set_e | wr_e;
   assign wr_ok = wr_e && (state != ST_RUN) && !reset;

   // Set beats Up/Down; opposing Up/Down cancel; auto-increment only when idle otherwise
   always_comb begin
      ptr_nxt = prog_ptr;
      if (set_e)
         ptr_nxt = set_addr;
      else if (up_e && dn_e)
         ptr_nxt = prog_ptr;
      else if (up_e)
         ptr_nxt = prog_ptr + 1'b1;
      else if (dn_e)
         ptr_nxt = prog_ptr - 1'b1;
      else if (AUTO_INC && wr_ok)
         ptr_nxt = prog_ptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         prog_ptr <= '0;
         running  <= 1'b0;
         prog_err <= 1'b0;
      end else begin
         prog_ptr <= ptr_nxt;
         if (wr_e && state == ST_RUN)
            prog_err <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end else if (any_e) begin
                  state   <= ST_PROG;
               end
            end
            ST_PROG: begin
               if (start) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!start && any_e) begin
                  state   <= ST_PROG;
                  running <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   // Memory is data only: survives reset, written with the pre-move pointer
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[prog_ptr] <= Imem_write_instr;
   end

   assign fetch_idx   = fetch_pc[AW+1:2];
   assign pc_ok       = ((fetch_pc >> (AW + 2)) == '0) && (fetch_pc[1:0] == 2'b00);
   assign fetch_instr = (state == ST_RUN && pc_ok) ? mem[fetch_idx] : NOP_WORD;

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Self-checking bench for imem_prog_ctrl: table-driven programming/fetch
// vectors with a write scoreboard, plus hand sequences for multi-cycle cases.
module tb_imem_prog_ctrl;
   import imem_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            reset, start, Imem_write_en, Up, Down, Set;
   logic [XLEN-1:0] Imem_write_instr, fetch_pc;
   logic [AW-1:0]   set_addr;
   logic [XLEN-1:0] fetch_instr, fetch_instr_ai;
   logic [AW-1:0]   prog_ptr, prog_ptr_ai;
   logic            running, running_ai, prog_err, prog_err_ai;

   int n_tests = 0;
   int n_fail  = 0;

   logic [XLEN-1:0] ref_mem [DEPTH];

   typedef struct {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] word;
   } wr_vec_t;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] want;
   } fetch_vec_t;

   wr_vec_t    prog_tab  [6];
   fetch_vec_t fetch_tab [7];
   wr_vec_t    exp_q [$];

   imem_prog_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .AUTO_INC(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start),
      .Imem_write_instr(Imem_write_instr), .Imem_write_en(Imem_write_en),
      .Up(Up), .Down(Down), .Set(Set), .set_addr(set_addr),
      .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .prog_ptr(prog_ptr), .running(running), .prog_err(prog_err)
   );

   imem_prog_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .AUTO_INC(1'b1)) dut_ai (
      .clk(clk), .reset(reset), .start(start),
      .Imem_write_instr(Imem_write_instr), .Imem_write_en(Imem_write_en),
      .Up(Up), .Down(Down), .Set(Set), .set_addr(set_addr),
      .fetch_pc(fetch_pc), .fetch_instr(fetch_instr_ai),
      .prog_ptr(prog_ptr_ai), .running(running_ai), .prog_err(prog_err_ai)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic do_set(input logic [AW-1:0] a);
      set_addr = a;
      Set = 1'b1;
      tick();
      Set = 1'b0;
      tick();
   endtask

   task automatic do_write(input logic [XLEN-1:0] d);
      Imem_write_instr = d;
      Imem_write_en = 1'b1;
      tick();
      Imem_write_en = 1'b0;
      tick();
   endtask

   task automatic do_up();
      Up = 1'b1;
      tick();
      Up = 1'b0;
      tick();
   endtask

   task automatic do_down();
      Down = 1'b1;
      tick();
      Down = 1'b0;
      tick();
   endtask

   task automatic fetch_check(input string name, input logic [XLEN-1:0] pc,
                              input logic [XLEN-1:0] want);
      fetch_pc = pc;
      #1;
      check(name, fetch_instr, want);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      prog_tab[0] = '{6'd0,  32'h1111_0093};
      prog_tab[1] = '{6'd2,  32'h2222_0113};
      prog_tab[2] = '{6'd31, 32'h3333_0193};
      prog_tab[3] = '{6'd62, 32'h4444_0213};
      prog_tab[4] = '{6'd5,  32'h5555_0293};
      prog_tab[5] = '{6'd63, 32'h6666_0313};

      fetch_tab[0] = '{32'h0000_0100, NOP};
      fetch_tab[1] = '{32'h0000_0002, NOP};
      fetch_tab[2] = '{32'h0000_0001, NOP};
      fetch_tab[3] = '{32'h8000_0004, NOP};
      fetch_tab[4] = '{32'h0000_00FF, NOP};
      fetch_tab[5] = '{32'h0000_00FC, 32'h6666_0313};
      fetch_tab[6] = '{32'h0000_0000, 32'h1111_0093};

      reset = 1'b1; start = 1'b0; Imem_write_en = 1'b0; Up = 1'b1;
      Down = 1'b0; Set = 1'b0; set_addr = '0; Imem_write_instr = '0; fetch_pc = '0;

      // Reset state, with Up held high through reset
      repeat (3) tick();
      check("reset_ptr", prog_ptr, 0);
      check("reset_running", running, 0);
      check("reset_err", prog_err, 0);
      check("reset_fetch_nop", fetch_instr, NOP);
      reset = 1'b0;
      tick(); tick();
      check("held_up_through_reset_ptr", prog_ptr, 0);
      check("held_up_through_reset_state", int'(dut.state), int'(ST_IDLE));
      Up = 1'b0;
      tick();

      // Held Up for three cycles acts once
      reset = 1'b1; tick(); reset = 1'b0; tick();
      Up = 1'b1;
      repeat (3) tick();
      Up = 1'b0;
      tick();
      check("hold_up_ptr", prog_ptr, 1);
      check("hold_up_state", int'(dut.state), int'(ST_PROG));
      check("prog_fetch_nop", fetch_instr, NOP);

      // Program one word then run
      do_set(6'd1);
      do_write(32'h00AE0E13);
      ref_mem[1] = 32'h00AE0E13;
      start = 1'b1;
      tick();
      check("run_running", running, 1);
      fetch_check("run_fetch_word1", 32'h4, 32'h00AE0E13);

      // Pointer wrap, cancel and Set priority
      start = 1'b0;
      do_set(6'd63);
      check("back_to_prog", int'(dut.state), int'(ST_PROG));
      check("set63_ptr", prog_ptr, 63);
      do_up();
      check("wrap_up_ptr", prog_ptr, 0);
      do_down();
      check("wrap_down_ptr", prog_ptr, 63);
      Up = 1'b1; Down = 1'b1; tick(); Up = 1'b0; Down = 1'b0; tick();
      check("up_down_cancel_ptr", prog_ptr, 63);
      set_addr = 6'd7; Set = 1'b1; Up = 1'b1; tick(); Set = 1'b0; Up = 1'b0; tick();
      check("set_beats_up_ptr", prog_ptr, 7);

      // Table-driven programming, scoreboarded
      foreach (prog_tab[i]) begin
         do_set(prog_tab[i].addr);
         do_write(prog_tab[i].word);
         ref_mem[prog_tab[i].addr] = prog_tab[i].word;
         exp_q.push_back(prog_tab[i]);
      end
      check("no_autoinc_ptr", prog_ptr, 63);
      fetch_check("prog_fetch_still_nop", 32'h0, NOP);
      start = 1'b1;
      tick();
      while (exp_q.size() > 0) begin
         wr_vec_t e;
         e = exp_q.pop_front();
         fetch_check($sformatf("sb_fetch_addr%0d", e.addr), {24'd0, e.addr, 2'b00}, e.word);
      end
      fetch_check("sb_fetch_word1_kept", 32'h4, ref_mem[1]);

      // Non-fetchable addresses in RUN
      foreach (fetch_tab[i])
         fetch_check($sformatf("fetch_tab%0d", i), fetch_tab[i].pc, fetch_tab[i].want);

      // Write in RUN is dropped and flags an error until reset
      do_write(32'hDEAD_BEEF);
      check("run_write_err", prog_err, 1);
      check("run_write_err_ai", prog_err_ai, 1);
      check("run_write_stays_run", running, 1);
      fetch_check("run_write_mem_unchanged", 32'hFC, ref_mem[63]);
      start = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0; tick();
      check("reset_clears_err", prog_err, 0);
      check("reset_running_low", running, 0);
      fetch_check("idle_fetch_nop", 32'hFC, NOP);
      start = 1'b1;
      tick();
      fetch_check("mem_kept_63", 32'hFC, ref_mem[63]);
      fetch_check("mem_kept_31", 32'h7C, ref_mem[31]);

      // Auto-increment instance: three writes, then write coinciding with Up
      start = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0; tick();
      do_write(32'hA000_0001);
      do_write(32'hB000_0002);
      do_write(32'hC000_0003);
      check("autoinc_ptr3", prog_ptr_ai, 3);
      check("plain_ptr_stays0", prog_ptr, 0);
      Imem_write_instr = 32'hD000_0004;
      Imem_write_en = 1'b1; Up = 1'b1; tick();
      Imem_write_en = 1'b0; Up = 1'b0; tick();
      check("autoinc_write_up_ptr", prog_ptr_ai, 4);
      check("plain_write_up_ptr", prog_ptr, 1);
      start = 1'b1;
      tick();
      check("autoinc_running", running_ai, 1);
      fetch_pc = 32'h0; #1; check("ai_mem0", fetch_instr_ai, 32'hA000_0001);
      fetch_pc = 32'h4; #1; check("ai_mem1", fetch_instr_ai, 32'hB000_0002);
      fetch_pc = 32'h8; #1; check("ai_mem2", fetch_instr_ai, 32'hC000_0003);
      fetch_pc = 32'hC; #1; check("ai_mem3", fetch_instr_ai, 32'hD000_0004);
      fetch_check("plain_mem0_last_write", 32'h0, 32'hD000_0004);
      fetch_check("plain_mem1_kept", 32'h4, 32'h00AE0E13);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
